// File: rtl/machine_timer_pkg.sv
// Shared register map, control bit positions and byte-lane helper for the machine timer.
// No logic of its own; pure constants and a combinational helper function.
// Not applicable (no handshake); consumers are the timer top and its bench-facing map.
package machine_timer_pkg;

    // Word offsets within the 32-byte timer window (memAddr[4:2])
    localparam logic [2:0] TIMER_MTIME_LO = 3'd0;
    localparam logic [2:0] TIMER_MTIME_HI = 3'd1;
    localparam logic [2:0] TIMER_CMP_LO   = 3'd2;
    localparam logic [2:0] TIMER_CMP_HI   = 3'd3;
    localparam logic [2:0] TIMER_CTRL     = 3'd4;
    localparam logic [2:0] TIMER_PRESC    = 3'd5;

    // CTRL register bit positions
    localparam int CTRL_RUN    = 0;
    localparam int CTRL_IRQ_EN = 1;

    // Machine timer interrupt cause code as seen on the CPU irqBus
    localparam logic [4:0] TIMER_IRQ_CAUSE = 5'd7;

    // Replace only the bytes whose lane is enabled in mask
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  lane_mask);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (lane_mask[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/machine_timer_prescaler.sv
// Divides the timer clock: one tick every divisor+1 enabled cycles.
// Latency: tick is combinational from the current count; count updates on the next edge.
// No backpressure; en=0 freezes the count, clr restarts the division period.
module machine_timer_prescaler #(
    parameter int PRE_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [PRE_W-1:0] divisor,
    input  logic             clr,
    output logic             tick
);

    logic [PRE_W-1:0] cnt;

    assign tick = en && (cnt == divisor);

    // Count enabled cycles, restarting on a tick or a divisor rewrite
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/machine_timer.sv
// Memory-mapped RISC-V mtime/mtimecmp block with optional prescaler (macro TIMER_PRESCALER_EN).
// Latency: reads are combinational same cycle; writes land on the next edge; irq is registered.
// No backpressure: every access completes in one cycle, the CPU port never stalls.
module machine_timer
    import machine_timer_pkg::*;
#(
    parameter logic [63:0] RESET_CMP = 64'hFFFF_FFFF_FFFF_FFFF,
    parameter int          PRE_W     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [3:0]  mask,
    input  logic [2:0]  addr,
    input  logic [31:0] wrData,
    output logic [31:0] rdData,
    output logic        irq
);

    if (PRE_W < 1 || PRE_W > 32) begin : g_pre_w_range
        $error("machine_timer: PRE_W must be within 1..32");
    end

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [1:0]  ctrl;
    logic        tick;

    logic wr_en;
    logic wr_lo;
    logic wr_hi;
    logic wr_cmp_lo;
    logic wr_cmp_hi;
    logic wr_ctrl;

    assign wr_en     = sel & we;
    assign wr_lo     = wr_en && (addr == TIMER_MTIME_LO);
    assign wr_hi     = wr_en && (addr == TIMER_MTIME_HI);
    assign wr_cmp_lo = wr_en && (addr == TIMER_CMP_LO);
    assign wr_cmp_hi = wr_en && (addr == TIMER_CMP_HI);
    assign wr_ctrl   = wr_en && (addr == TIMER_CTRL) && mask[0];

`ifdef TIMER_PRESCALER_EN
    logic [PRE_W-1:0] presc;
    logic             wr_presc;

    // A PRESC store with no lanes enabled is not a write and leaves the count alone
    assign wr_presc = wr_en && (addr == TIMER_PRESC) && (|mask);

    // Divisor register; only the implemented low PRE_W bits are stored
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
        end else if (wr_presc) begin
            for (int i = 0; i < PRE_W; i++) begin
                if (mask[i/8]) begin
                    presc[i] <= wrData[i];
                end
            end
        end
    end

    machine_timer_prescaler #(
        .PRE_W   (PRE_W)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .en      (ctrl[CTRL_RUN]),
        .divisor (presc),
        .clr     (wr_presc),
        .tick    (tick)
    );
`else
    assign tick = ctrl[CTRL_RUN];
`endif

    // Increment first, then let software bytes override; the untouched half keeps the carry
    logic [63:0] mtime_inc;
    logic [63:0] mtime_nxt;

    assign mtime_inc = mtime + {63'd0, tick};

    // Merge any software write into the incremented count
    always_comb begin
        mtime_nxt = mtime_inc;
        if (wr_lo) begin
            mtime_nxt[31:0] = merge_lanes(mtime_inc[31:0], wrData, mask);
        end
        if (wr_hi) begin
            mtime_nxt[63:32] = merge_lanes(mtime_inc[63:32], wrData, mask);
        end
    end

    // Counter, compare and control registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mtime    <= '0;
            mtimecmp <= RESET_CMP;
            ctrl     <= '0;
        end else begin
            mtime <= mtime_nxt;
            if (wr_cmp_lo) begin
                mtimecmp[31:0] <= merge_lanes(mtimecmp[31:0], wrData, mask);
            end
            if (wr_cmp_hi) begin
                mtimecmp[63:32] <= merge_lanes(mtimecmp[63:32], wrData, mask);
            end
            if (wr_ctrl) begin
                ctrl <= wrData[1:0];
            end
        end
    end

    // Registered level interrupt from the unsigned 64-bit compare
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq <= 1'b0;
        end else begin
            irq <= ctrl[CTRL_IRQ_EN] & (mtime >= mtimecmp);
        end
    end

    // Same-cycle read mux; idle bus reads as zero
    always_comb begin
        rdData = '0;
        if (sel) begin
            case (addr)
                TIMER_MTIME_LO: rdData = mtime[31:0];
                TIMER_MTIME_HI: rdData = mtime[63:32];
                TIMER_CMP_LO:   rdData = mtimecmp[31:0];
                TIMER_CMP_HI:   rdData = mtimecmp[63:32];
                TIMER_CTRL:     rdData = {30'd0, ctrl};
`ifdef TIMER_PRESCALER_EN
                TIMER_PRESC:    rdData[PRE_W-1:0] = presc;
`endif
                default:        rdData = '0;
            endcase
        end
    end

endmodule
